// File: rtl/quad_pkg.sv
// quad_pkg: shared definitions for the multi-channel quadrature decoder.
// Holds the step codes, the Gray-code transition decoder and the signed
// position limits derived from the counter width.
package quad_pkg;

    localparam logic [1:0] STEP_NONE = 2'd0;
    localparam logic [1:0] STEP_FWD  = 2'd1;
    localparam logic [1:0] STEP_REV  = 2'd2;
    localparam logic [1:0] STEP_ERR  = 2'd3;

    // Map {previous AB, new AB} to a step code using the x4 Gray sequence
    // 00 -> 01 -> 11 -> 10 -> 00 as the forward direction.
    function automatic logic [1:0] decodeStep(input logic [3:0] prevNew);
        logic [1:0] code;
        code = STEP_NONE;
        case (prevNew)
            4'b0001, 4'b0111, 4'b1110, 4'b1000: code = STEP_FWD;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: code = STEP_REV;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: code = STEP_ERR;
            default:                            code = STEP_NONE;
        endcase
        return code;
    endfunction

    // Largest positive value of a cw-bit two's complement counter.
    function automatic int posMax(input int cw);
        return (1 << (cw - 1)) - 1;
    endfunction

    // Most negative value of a cw-bit two's complement counter.
    function automatic int posMin(input int cw);
        return -(1 << (cw - 1));
    endfunction

endpackage

// File: rtl/quad_chan.sv
// quad_chan: one encoder channel. Synchronises the raw A/B pins, filters
// them on the shared sample tick, arms on the first accepted value, decodes
// x4 Gray transitions and keeps a signed position counter.
// Optional: QUAD_VELOCITY_EN adds a per-window step accumulator (vel_o).
module quad_chan
    import quad_pkg::*;
#(
    parameter int CW   = 9,
    parameter int FILT = 3,
    parameter int SAT  = 0
`ifdef QUAD_VELOCITY_EN
    ,
    parameter int VWIN = 64
`endif
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          tick_i,
    input  logic          encA_i,
    input  logic          encB_i,
    input  logic          clr_i,
    output logic [CW-1:0] pos_o,
    output logic          step_o,
    output logic          dir_o,
    output logic          err_o
`ifdef QUAD_VELOCITY_EN
    ,
    output logic [CW-1:0] vel_o
`endif
);

    localparam logic [3:0]    FILT_N    = 4'(FILT);
    localparam int            POS_MAX_I = posMax(CW);
    localparam int            POS_MIN_I = posMin(CW);
    localparam logic [CW-1:0] POS_MAX   = POS_MAX_I[CW-1:0];
    localparam logic [CW-1:0] POS_MIN   = POS_MIN_I[CW-1:0];
    localparam logic [CW-1:0] POS_ONE   = CW'(1);
    localparam bit            SAT_EN    = (SAT != 0);

    logic [1:0]    syncA_q, syncB_q;
    logic [1:0]    sample;
    logic [1:0]    cand_q, cand_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [1:0]    filt_q, filt_d;
    logic          valid_q, valid_d;
    logic          change;
    logic [1:0]    code;
    logic          armed_q, armed_d;
    logic [CW-1:0] pos_q, pos_d;
    logic          step_q, step_d;
    logic          dir_q, dir_d;
    logic          err_q, err_d;

    // Two-flop synchroniser on each raw encoder line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            syncA_q <= '0;
            syncB_q <= '0;
        end else begin
            syncA_q <= {syncA_q[0], encA_i};
            syncB_q <= {syncB_q[0], encB_i};
        end
    end

    // Tick-driven glitch filter; a value is accepted once stable for FILT
    // ticks, and the very first stable value after reset is always accepted.
    always_comb begin
        sample  = {syncA_q[1], syncB_q[1]};
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        filt_d  = filt_q;
        valid_d = valid_q;
        change  = 1'b0;
        if (tick_i) begin
            if (sample == cand_q) begin
                if (cnt_q < FILT_N) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                cand_d = sample;
                cnt_d  = 4'd1;
            end
            if ((cnt_d == FILT_N) && (!valid_q || (cand_d != filt_q))) begin
                filt_d  = cand_d;
                valid_d = 1'b1;
                change  = 1'b1;
            end
        end
    end

    // Arming, decode and position update; clear overrides any count.
    always_comb begin
        code    = decodeStep({filt_q, cand_d});
        armed_d = armed_q;
        pos_d   = pos_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
        err_d   = err_q;
        if (clr_i) begin
            pos_d   = '0;
            err_d   = 1'b0;
            armed_d = 1'b0;
        end else if (change) begin
            if (!armed_q) begin
                armed_d = 1'b1;
            end else begin
                case (code)
                    STEP_FWD: begin
                        if (!(SAT_EN && (pos_q == POS_MAX))) begin
                            pos_d  = pos_q + POS_ONE;
                            step_d = 1'b1;
                            dir_d  = 1'b1;
                        end
                    end
                    STEP_REV: begin
                        if (!(SAT_EN && (pos_q == POS_MIN))) begin
                            pos_d  = pos_q - POS_ONE;
                            step_d = 1'b1;
                            dir_d  = 1'b0;
                        end
                    end
                    STEP_ERR: err_d = 1'b1;
                    default:  ;
                endcase
            end
        end
    end

    // Channel state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cand_q  <= '0;
            cnt_q   <= '0;
            filt_q  <= '0;
            valid_q <= 1'b0;
            armed_q <= 1'b0;
            pos_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
            valid_q <= valid_d;
            armed_q <= armed_d;
            pos_q   <= pos_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    assign pos_o  = pos_q;
    assign step_o = step_q;
    assign dir_o  = dir_q;
    assign err_o  = err_q;

`ifdef QUAD_VELOCITY_EN
    logic signed [31:0] acc_q, acc_d, accSum;
    logic        [31:0] win_q, win_d;
    logic      [CW-1:0] vel_q, vel_d;

    // Sum signed steps over VWIN ticks, then publish a saturated rate.
    always_comb begin
        accSum = acc_q;
        if (step_d) begin
            accSum = dir_d ? (acc_q + 32'sd1) : (acc_q - 32'sd1);
        end
        acc_d = accSum;
        win_d = win_q;
        vel_d = vel_q;
        if (tick_i) begin
            if (win_q == 32'(VWIN - 1)) begin
                win_d = '0;
                acc_d = '0;
                if (accSum > POS_MAX_I) begin
                    vel_d = POS_MAX;
                end else if (accSum < POS_MIN_I) begin
                    vel_d = POS_MIN;
                end else begin
                    vel_d = accSum[CW-1:0];
                end
            end else begin
                win_d = win_q + 32'd1;
            end
        end
        if (clr_i) begin
            acc_d = '0;
        end
    end

    // Velocity window registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            win_q <= '0;
            vel_q <= '0;
        end else begin
            acc_q <= acc_d;
            win_q <= win_d;
            vel_q <= vel_d;
        end
    end

    assign vel_o = vel_q;
`endif

endmodule

// File: rtl/quad_decoder_mc.sv
// quad_decoder_mc: multi-channel quadrature encoder front end in the
// CLOCK_50 domain. Generates the shared sample tick and one quad_chan per
// encoder, slicing the packed position bus per channel.
// Optional: QUAD_VELOCITY_EN adds parameter VWIN and the vel output bus.
module quad_decoder_mc
    import quad_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int CW   = 9,
    parameter int DIV  = 50000,
    parameter int FILT = 3,
    parameter int SAT  = 0
`ifdef QUAD_VELOCITY_EN
    ,
    parameter int VWIN = 64
`endif
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic [NCH-1:0]    enc_a,
    input  logic [NCH-1:0]    enc_b,
    input  logic [NCH-1:0]    clr,
    output logic [NCH*CW-1:0] pos,
    output logic [NCH-1:0]    step,
    output logic [NCH-1:0]    dir,
    output logic [NCH-1:0]    err
`ifdef QUAD_VELOCITY_EN
    ,
    output logic [NCH*CW-1:0] vel
`endif
);

    localparam int            TW        = $clog2(DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    logic [TW-1:0] tickCnt_q, tickCnt_d;
    logic          tick;

    // Tick divider: count 0..DIV-1, tick on the last count, then wrap.
    always_comb begin
        tick      = (tickCnt_q == TICK_LAST);
        tickCnt_d = tick ? '0 : (tickCnt_q + TICK_ONE);
    end

    // Tick counter register.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            tickCnt_q <= '0;
        end else begin
            tickCnt_q <= tickCnt_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : gChan
        quad_chan #(
            .CW   (CW),
            .FILT (FILT),
            .SAT  (SAT)
`ifdef QUAD_VELOCITY_EN
            ,
            .VWIN (VWIN)
`endif
        ) uChan (
            .clk_i  (CLOCK_50),
            .rst_ni (rst_n),
            .tick_i (tick),
            .encA_i (enc_a[i]),
            .encB_i (enc_b[i]),
            .clr_i  (clr[i]),
            .pos_o  (pos[i*CW +: CW]),
            .step_o (step[i]),
            .dir_o  (dir[i]),
            .err_o  (err[i])
`ifdef QUAD_VELOCITY_EN
            ,
            .vel_o  (vel[i*CW +: CW])
`endif
        );
    end

endmodule

// File: tb/tb_quad_decoder_mc.sv
// tb_quad_decoder_mc: drives two decoder instances (wrapping and saturating)
// with the same pin activity and compares them every cycle against a
// behavioural model built from Gray-index arithmetic, plus directed checks.
module tb_quad_decoder_mc;

    localparam int NCH    = 2;
    localparam int CW     = 9;
    localparam int DIV    = 4;
    localparam int FILT   = 2;
    localparam int POS_HI = 255;
    localparam int POS_LO = -256;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    encA  = '0;
    logic [NCH-1:0]    encB  = '0;
    logic [NCH-1:0]    clr   = '0;
    logic [NCH*CW-1:0] posW, posS;
    logic [NCH-1:0]    stepW, dirW, errW, stepS, dirS, errS;
`ifdef QUAD_VELOCITY_EN
    logic [NCH*CW-1:0] velW, velS;
`endif

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkEn     = 1'b0;
    int stepCntW    = 0;
    int stepCntS    = 0;
    int baseW, baseS;

    // Gray position index of an AB value, and AB value of a Gray index.
    int         grayIdx[4] = '{0, 1, 3, 2};
    logic [1:0] grayVal[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    // Behavioural model state; instance 0 wraps, instance 1 saturates.
    logic [1:0] mPipe1[NCH], mPipe2[NCH], mCand[NCH], mFilt[NCH];
    int         mCnt[NCH];
    bit         mValid[NCH], mArmed[NCH];
    int         mPos[2][NCH];
    bit         mStep[2][NCH], mDir[2][NCH], mErr[2][NCH];
    int         mCyc;
    logic [1:0] curAB[NCH];

    quad_decoder_mc #(.NCH(NCH), .CW(CW), .DIV(DIV), .FILT(FILT), .SAT(0)) dutWrap (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .enc_a    (encA),
        .enc_b    (encB),
        .clr      (clr),
        .pos      (posW),
        .step     (stepW),
        .dir      (dirW),
        .err      (errW)
`ifdef QUAD_VELOCITY_EN
        ,
        .vel      (velW)
`endif
    );

    quad_decoder_mc #(.NCH(NCH), .CW(CW), .DIV(DIV), .FILT(FILT), .SAT(1)) dutSat (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .enc_a    (encA),
        .enc_b    (encB),
        .clr      (clr),
        .pos      (posS),
        .step     (stepS),
        .dir      (dirS),
        .err      (errS)
`ifdef QUAD_VELOCITY_EN
        ,
        .vel      (velS)
`endif
    );

    // 50 MHz-style clock.
    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mCyc = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            mPipe1[ch] = 2'b00;
            mPipe2[ch] = 2'b00;
            mCand[ch]  = 2'b00;
            mFilt[ch]  = 2'b00;
            mCnt[ch]   = 0;
            mValid[ch] = 1'b0;
            mArmed[ch] = 1'b0;
            for (int k = 0; k < 2; k++) begin
                mPos[k][ch]  = 0;
                mStep[k][ch] = 1'b0;
                mDir[k][ch]  = 1'b0;
                mErr[k][ch]  = 1'b0;
            end
        end
    endtask

    task automatic modelClock();
        bit         tick;
        bit         ev;
        logic [1:0] smp, prev;
        int         d, np;
        tick = ((mCyc % DIV) == DIV - 1);
        mCyc++;
        for (int ch = 0; ch < NCH; ch++) begin
            smp        = mPipe2[ch];
            mPipe2[ch] = mPipe1[ch];
            mPipe1[ch] = {encA[ch], encB[ch]};
            prev       = mFilt[ch];
            ev         = 1'b0;
            if (tick) begin
                if (smp == mCand[ch]) begin
                    if (mCnt[ch] < FILT) mCnt[ch]++;
                end else begin
                    mCand[ch] = smp;
                    mCnt[ch]  = 1;
                end
                if (mCnt[ch] == FILT && (!mValid[ch] || mCand[ch] != mFilt[ch])) begin
                    mFilt[ch]  = mCand[ch];
                    mValid[ch] = 1'b1;
                    ev         = 1'b1;
                end
            end
            for (int k = 0; k < 2; k++) mStep[k][ch] = 1'b0;
            if (clr[ch]) begin
                mArmed[ch] = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    mPos[k][ch] = 0;
                    mErr[k][ch] = 1'b0;
                end
            end else if (ev) begin
                if (!mArmed[ch]) begin
                    mArmed[ch] = 1'b1;
                end else begin
                    d = (grayIdx[mFilt[ch]] - grayIdx[prev] + 4) % 4;
                    for (int k = 0; k < 2; k++) begin
                        if (d == 2) begin
                            mErr[k][ch] = 1'b1;
                        end else begin
                            np = mPos[k][ch] + ((d == 1) ? 1 : -1);
                            if (!(k == 1 && (np > POS_HI || np < POS_LO))) begin
                                if (np > POS_HI) np -= (1 << CW);
                                if (np < POS_LO) np += (1 << CW);
                                mPos[k][ch]  = np;
                                mStep[k][ch] = 1'b1;
                                mDir[k][ch]  = (d == 1);
                            end
                        end
                    end
                end
            end
        end
    endtask

    // Advance the model on every clock edge and on asynchronous reset.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else        modelClock();
        end
    end

    // Compare both instances against the model every falling edge.
    always @(negedge clk) begin
        logic [NCH*CW-1:0] ePosW, ePosS;
        logic [NCH-1:0]    eStepW, eDirW, eErrW, eStepS, eDirS, eErrS;
        if (checkEn) begin
            for (int ch = 0; ch < NCH; ch++) begin
                ePosW[ch*CW +: CW] = mPos[0][ch][CW-1:0];
                ePosS[ch*CW +: CW] = mPos[1][ch][CW-1:0];
                eStepW[ch] = mStep[0][ch];
                eDirW[ch]  = mDir[0][ch];
                eErrW[ch]  = mErr[0][ch];
                eStepS[ch] = mStep[1][ch];
                eDirS[ch]  = mDir[1][ch];
                eErrS[ch]  = mErr[1][ch];
            end
            checkOutput("model posWrap", posW, ePosW);
            checkOutput("model stepWrap", stepW, eStepW);
            checkOutput("model dirWrap", dirW, eDirW);
            checkOutput("model errWrap", errW, eErrW);
            checkOutput("model posSat", posS, ePosS);
            checkOutput("model stepSat", stepS, eStepS);
            checkOutput("model dirSat", dirS, eDirS);
            checkOutput("model errSat", errS, eErrS);
        end
    end

    // Count channel-0 step pulses, sampled just after the falling edge.
    always begin
        @(negedge clk);
        #2;
        if (stepW[0]) stepCntW++;
        if (stepS[0]) stepCntS++;
    end

    task automatic applyStimulus(input logic [1:0] ab0, input logic [1:0] ab1,
                                 input int ticks);
        curAB[0] = ab0;
        curAB[1] = ab1;
        encA     = {ab1[1], ab0[1]};
        encB     = {ab1[0], ab0[0]};
        repeat (ticks * DIV) @(negedge clk);
    endtask

    task automatic stepCh0(input int dirn, input int ticks);
        logic [1:0] nxt;
        nxt = grayVal[(grayIdx[curAB[0]] + dirn + 4) % 4];
        applyStimulus(nxt, curAB[1], ticks);
    endtask

    task automatic settle();
        applyStimulus(curAB[0], curAB[1], 2);
    endtask

    task automatic pulseClr(input logic [NCH-1:0] mask);
        clr = mask;
        @(negedge clk);
        clr = '0;
        @(negedge clk);
    endtask

    task automatic asyncResetCheck();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #2;
        checkOutput("async posWrap", posW, '0);
        checkOutput("async posSat", posS, '0);
        checkOutput("async step", stepW, '0);
        checkOutput("async dir", dirW, '0);
        checkOutput("async err", errW, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Directed sequence followed by randomised pin activity.
    initial begin
        for (int ch = 0; ch < NCH; ch++) curAB[ch] = 2'b00;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        checkEn = 1'b1;
        @(negedge clk);
        checkOutput("reset posWrap", posW, '0);
        checkOutput("reset posSat", posS, '0);
        checkOutput("reset step", stepW, '0);
        checkOutput("reset dir", dirW, '0);
        checkOutput("reset err", errW, '0);

        applyStimulus(2'b00, 2'b00, 3);
        baseW = stepCntW;
        for (int i = 0; i < 4; i++) stepCh0(1, 3);
        settle();
        checkOutput("fwd pos0", posW[CW-1:0], 9'd4);
        checkOutput("fwd steps0", stepCntW - baseW, 4);
        checkOutput("fwd dir0", dirW[0], 1'b1);
        checkOutput("fwd pos1", posW[2*CW-1:CW], 9'd0);

        for (int i = 0; i < 4; i++) stepCh0(-1, 3);
        settle();
        checkOutput("rev pos0", posW[CW-1:0], 9'd0);
        checkOutput("rev dir0", dirW[0], 1'b0);
        for (int i = 0; i < 4; i++) stepCh0(-1, 3);
        settle();
        checkOutput("rev2 pos0", posW[CW-1:0], 9'h1FC);
        checkOutput("rev2 steps0", stepCntW - baseW, 12);

        baseW = stepCntW;
        applyStimulus(2'b01, 2'b00, 1);
        applyStimulus(2'b00, 2'b00, 3);
        checkOutput("glitch1 pos0", posW[CW-1:0], 9'h1FC);
        checkOutput("glitch1 steps0", stepCntW - baseW, 0);
        applyStimulus(2'b01, 2'b00, 2);
        applyStimulus(2'b00, 2'b00, 3);
        checkOutput("glitch2 steps0", stepCntW - baseW, 2);
        checkOutput("glitch2 pos0", posW[CW-1:0], 9'h1FC);

        applyStimulus(2'b11, 2'b00, 3);
        checkOutput("jump err0", errW[0], 1'b1);
        checkOutput("jump err1", errW[1], 1'b0);
        checkOutput("jump pos0", posW[CW-1:0], 9'h1FC);
        pulseClr(2'b01);
        checkOutput("clr err0", errW[0], 1'b0);
        checkOutput("clr pos0", posW[CW-1:0], 9'd0);
        baseW = stepCntW;
        applyStimulus(2'b10, 2'b00, 3);
        checkOutput("rearm pos0", posW[CW-1:0], 9'd0);
        checkOutput("rearm steps0", stepCntW - baseW, 0);
        applyStimulus(2'b00, 2'b00, 3);
        settle();
        checkOutput("postarm pos0", posW[CW-1:0], 9'd1);
        checkOutput("postarm dir0", dirW[0], 1'b1);

        for (int i = 0; i < 254; i++) stepCh0(1, 3);
        settle();
        checkOutput("max posWrap0", posW[CW-1:0], 9'd255);
        checkOutput("max posSat0", posS[CW-1:0], 9'd255);
        baseW = stepCntW;
        baseS = stepCntS;
        stepCh0(1, 3);
        settle();
        checkOutput("over posWrap0", posW[CW-1:0], 9'h100);
        checkOutput("over posSat0", posS[CW-1:0], 9'h0FF);
        checkOutput("over stepsWrap0", stepCntW - baseW, 1);
        checkOutput("over stepsSat0", stepCntS - baseS, 0);

        for (int it = 0; it < 200; it++) begin
            if (it == 100) asyncResetCheck();
            applyStimulus(2'($urandom_range(3)), 2'($urandom_range(3)),
                          int'($urandom_range(4, 1)));
            if ($urandom_range(7) == 0) pulseClr(2'($urandom_range(3)));
        end
        settle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/quad_decoder_mc.md
Name: quad_decoder_mc

Overview:
- Multi-channel quadrature encoder decoder. Next generation of the single-channel rotary-encoder front end.
- Per channel: input synchronisation, a glitch filter clocked by a shared sample tick, x4 Gray-code decoding, and a signed position counter.
- Adds per-channel clear, illegal-transition detection, and selectable wrap/saturate.
- Sits between the board header pins and LED or user logic, all in the CLOCK_50 domain.

Parameters:
- NCH, 2, number of encoder channels (1..8).
- CW, 9, position counter width per channel, two's complement.
- DIV, 50000, CLOCK_50 cycles per sample tick (>=2).
- FILT, 3, consecutive identical samples needed to accept a new A/B value (1..15).
- SAT, 0, 0 = position wraps; 1 = position saturates at +2^(CW-1)-1 / -2^(CW-1).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- enc_a  in  NCH  raw encoder A lines, asynchronous.
- enc_b  in  NCH  raw encoder B lines, asynchronous.
- clr  in  NCH  synchronous per-channel clear of position and error.
- pos  out  NCH*CW  signed positions; channel i occupies [i*CW +: CW].
- step  out  NCH  one-clock pulse whenever pos of that channel changes.
- dir  out  NCH  direction of last accepted step; 1 = forward, 0 = reverse.
- err  out  NCH  sticky flag: illegal (double-bit) transition seen.

Behaviour:
- Reset (rst_n low, asynchronous): pos=0, step=0, dir=0, err=0, tick counter=0, filter counters=0, armed=0 on all channels.
- Synchroniser: 2-FF on every enc_a/enc_b bit.
- Tick: counter runs 0..DIV-1; tick is high for one cycle when counter==DIV-1, then counter returns to 0. One tick is shared by all channels.
- Filter, evaluated on tick only, per channel:
  - Sample {A,B} equals candidate: stable count increments, saturating at FILT.
  - Sample differs from candidate: candidate = sample, stable count = 1.
  - Stable count reaches FILT and candidate != filtered: filtered = candidate and a change event fires.
  - FILT=1 accepts every tick sample.
- Arming: the first accepted filtered value after reset or clr only loads filtered, sets armed=1, and produces no count.
- Decode, on a change event when armed, prev -> new:
  - Forward (+1): 00->01, 01->11, 11->10, 10->00.
  - Reverse (-1): the inverse transitions.
  - Both bits changed (00<->11, 01<->10): err=1, pos unchanged, no step.
- Latency: pos, step and dir update on the clock after the tick that accepts the change. Raw pin to pos is 2 sync cycles + FILT ticks + 1 cycle.
- Arithmetic:
  - SAT=0: wraps modulo 2^CW.
  - SAT=1: a step that would exceed a limit holds pos at the limit, and step stays 0.
- clr[i] high:
  - Next clock: pos=0, err=0, armed=0, step=0.
  - clr wins over a simultaneous count. Filter state is preserved. dir is unchanged.
- Channels are fully independent. Simultaneous events on different channels all take effect in the same cycle.

Optional Feature:
- QUAD_VELOCITY_EN defined:
  - Adds parameter VWIN (default 64, ticks per window) and output vel (NCH*CW, signed).
  - Per channel, signed steps are accumulated over VWIN ticks. At window end, vel = accumulated value (saturated to CW bits) and the accumulator resets.
  - clr also zeroes the accumulator. vel resets to 0.
- QUAD_VELOCITY_EN undefined: no vel port and no accumulator logic.

Decomposition:
- Package quad_pkg:
  - step-code constants STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR (2 bits).
  - decode function mapping {prev,new} 4 bits to a step code.
  - POS_MAX/POS_MIN derivation from CW.
- Sub-module quad_chan: sync + filter + arming + decode + counter (+ velocity) for one channel. Generated NCH times.
- Top level: tick divider and port slicing.

Test Plan:
- Bench parameters: DIV=4, FILT=2, CW=9, NCH=2.
- Reset then ch0 driven 00->01->11->10->00, each held 3 ticks -> after arming on 00, pos0=+4, four step0 pulses, dir0=1, pos1=0.
- Reverse sequence 4 steps from pos0=+4 -> pos0=0, dir0=0. Repeat once more -> pos0=-4 (0x1FC).
- A/B glitch lasting 1 tick -> no step, pos unchanged. Glitch held 2 ticks -> accepted.
- Jump 00->11 in one tick -> err0=1, pos0 unchanged. Pulse clr0 -> err0=0, pos0=0, next value only re-arms.
- SAT=1, pos0 = +255, one more forward step -> pos0 stays 255, no step. SAT=0 same stimulus -> pos0 = -256.
- Assert rst_n low mid-sequence asynchronously -> all outputs 0 immediately, before the next CLOCK_50 edge.
